fifo_wr_arbiter: RTL

- Write-side scheduler for the asynchronous FIFO's write domain.
- Shares the single FIFO write port between two requesters:
  - A: 16-bit ALU result, sent as two bytes, LSB first.
  - B: 8-bit register-file read data.
- Round-robin arbitration, valid/ready handshake per requester; drives the FIFO write enable and write data, and throttles on the FIFO full flag.
- Sits entirely in the write clock domain, between the system controller datapath and the FIFO.

---
 rtl/fifo_wr_arbiter_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_arb2.sv | 22 ++
 rtl/fifo_wr_arbiter.sv | 62 ++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared state encoding, grant codes and default widths for the FIFO write arbiter
package fifo_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEND_B  = 2'b01,
        SEND_LO = 2'b10,
        SEND_HI = 2'b11
    } state_t;
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH = 16;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshakes, FIFO write port and status of the write arbiter
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                    i_a_valid;
    logic [2*DATA_WIDTH-1:0] i_a_data;
    logic                    o_a_ready;
    logic                    i_b_valid;
    logic [DATA_WIDTH-1:0]   i_b_data;
    logic                    o_b_ready;
    logic                    i_fifo_full;
    logic                    o_fifo_winc;
    logic [DATA_WIDTH-1:0]   o_fifo_wdata;
    logic                    o_busy;
    logic                    o_grant;
    logic [CNT_WIDTH-1:0]    o_wr_count;
    modport slave (
        input  i_a_valid, i_a_data, i_b_valid, i_b_data, i_fifo_full,
        output o_a_ready, o_b_ready, o_fifo_winc, o_fifo_wdata, o_busy, o_grant, o_wr_count
    );
    modport master (
        output i_a_valid, i_a_data, i_b_valid, i_b_data, i_fifo_full,
        input  o_a_ready, o_b_ready, o_fifo_winc, o_fifo_wdata, o_busy, o_grant, o_wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, one-hot grant, pointer moves to the loser on each grant
module rr_arb2
    import fifo_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_ptr;
    logic w_pick_b;
    assign w_pick_b = i_req[1] && (!i_req[0] || r_ptr == GNT_B);
    assign o_gnt = i_en ? {w_pick_b, i_req[0] && !w_pick_b} : 2'b00;
    // point at the requester that lost (or was not granted) so a tie next time goes to it
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ptr <= GNT_A;
        else if (|o_gnt)
            r_ptr <= o_gnt[0] ? GNT_B : GNT_A;
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the FIFO write port between a 16-bit requester (two bytes, LSB first) and a byte requester
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input logic i_clk,
    input logic i_rst,
    fifo_wr_arbiter_if.slave bus
);
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold_lo;
    logic [DATA_WIDTH-1:0] r_hold_hi;
    logic                  r_grant;
    logic [CNT_WIDTH-1:0]  r_wr_count;
    logic [1:0]            w_gnt;
    logic                  w_idle;
    logic                  w_winc;
    // reset gates both the grant and the write so nothing is accepted or written on a reset edge
    assign w_idle = r_state == IDLE && !i_rst;
    assign w_winc = r_state != IDLE && !i_rst && !bus.i_fifo_full;
    rr_arb2 u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_idle),
        .i_req ({bus.i_b_valid, bus.i_a_valid}),
        .o_gnt (w_gnt)
    );
    assign bus.o_a_ready    = w_gnt[0];
    assign bus.o_b_ready    = w_gnt[1];
    assign bus.o_fifo_winc  = w_winc;
    assign bus.o_fifo_wdata = r_state == SEND_HI ? r_hold_hi : r_hold_lo;
    assign bus.o_busy       = r_state != IDLE;
    assign bus.o_grant      = r_grant;
    assign bus.o_wr_count   = r_wr_count;
    // capture the granted word in IDLE, then step through its bytes only on cycles the FIFO takes one
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_hold_lo  <= '0;
            r_hold_hi  <= '0;
            r_grant    <= GNT_A;
            r_wr_count <= '0;
        end else begin
            if (w_winc)
                r_wr_count <= r_wr_count + 1'b1;
            if (w_gnt[0]) begin
                r_hold_lo <= bus.i_a_data[DATA_WIDTH-1:0];
                r_hold_hi <= bus.i_a_data[2*DATA_WIDTH-1:DATA_WIDTH];
                r_grant   <= GNT_A;
                r_state   <= SEND_LO;
            end else if (w_gnt[1]) begin
                r_hold_lo <= bus.i_b_data;
                r_grant   <= GNT_B;
                r_state   <= SEND_B;
            end else if (w_winc) begin
                r_state <= r_state == SEND_LO ? SEND_HI : IDLE;
            end
        end
    end
endmodule
